status_array_ctrl: RTL and testbench
====================================

Name: status_array_ctrl

Overview:
Parametrised status array for the instruction cache. It holds per-block status bits (valid/LRU) for every set in a flop-based array and serves masked writes and tagged reads through a valid/ready interface. It contains its own initialisation sequencer, which clears every row after reset and after a flush, so downstream logic never sees uninitialised status. It sits beside the tag and data arrays in the lookup pipeline.

Parameters:
NUM_ROWS, 16, number of sets; must be a power of 2 and at least 2.
NUM_BLOCKS, 4, blocks per row; also the width of the write mask.
BLOCK_WIDTH, 2, status bits per block.
TAG_WIDTH, 1, width of the sideband tag carried with each request.
INIT_BLOCK, 0, BLOCK_WIDTH-bit value written into every block during initialisation.
OUT_REG, 0, 0 gives read latency 1; 1 adds an output register stage and gives read latency 2.
Derived (not overridable): ADDR_WIDTH = $clog2(NUM_ROWS); ROW_WIDTH = NUM_BLOCKS*BLOCK_WIDTH.

Ports:
gated_clk  in  1  clock; already gated upstream, so a stopped clock freezes all state.
arst_n  in  1  reset; asynchronous, active-low.
i_flush  in  1  single-cycle pulse that re-initialises the whole array.
i_valid  in  1  request valid.
i_wen  in  1  1 = masked write, 0 = read.
i_addr  in  ADDR_WIDTH  row index.
i_wmask  in  NUM_BLOCKS  per-block write enable; bit k covers data bits [k*BLOCK_WIDTH +: BLOCK_WIDTH].
i_data  in  ROW_WIDTH  write data.
i_tag  in  TAG_WIDTH  sideband tag, returned with read data.
o_ready  out  1  array can accept a request this cycle.
o_init_busy  out  1  initialisation sequence is in progress.
o_valid  out  1  read data valid.
o_data  out  ROW_WIDTH  read row; all zeros whenever o_valid=0.
o_tag  out  TAG_WIDTH  tag of the returned read; all zeros whenever o_valid=0.

Behaviour:
- Storage: NUM_ROWS x ROW_WIDTH flops with no reset. Their contents are defined only by the init sequencer and by writes.
- FSM has two states, INIT and RUN.
  - Reset value: state=INIT, row counter=0.
  - INIT: each cycle writes {NUM_BLOCKS{INIT_BLOCK}} to row[counter] and increments the counter. When the counter reaches NUM_ROWS-1, the final write completes and the FSM moves to RUN. INIT lasts exactly NUM_ROWS cycles.
  - RUN: when i_flush=1, the FSM moves to INIT and the counter is set to 0.
  - i_flush is ignored while in INIT; the sequence is not restarted.
- o_init_busy = (state==INIT). o_ready = (state==RUN) & ~i_flush.
- A request is accepted when i_valid & o_ready. Requests presented while o_ready=0 are dropped: no write occurs and no o_valid is produced.
- Accepted write: only the masked blocks of row[i_addr] are updated, at the next clock edge. A write produces no o_valid. A write with i_wmask=0 is a no-op.
- Accepted read:
  - OUT_REG=0: o_valid=1 in cycle N+1, with o_data = row contents at edge N+1 and o_tag = i_tag.
  - OUT_REG=1: the same values appear in cycle N+2.
  - Back-to-back reads give one result per cycle.
- Read following a write: a read in cycle N+1 to a row written in cycle N returns the new data; no hazard exists.
- Pipeline vs flush: a read accepted before the flush cycle completes normally and returns pre-flush data. An o_valid in flight in the OUT_REG stage is unaffected by a flush.
- o_valid register reset value is 0. o_data and o_tag are masked by o_valid, so they read 0 out of reset.
- Reset asserted mid-INIT or mid-RUN: the FSM returns to INIT, the counter goes to 0 and all o_valid stages clear. After release, the full NUM_ROWS-cycle init runs again.
- Address is always in range because NUM_ROWS is a power of 2. The counter is ADDR_WIDTH bits wide and does not wrap past the last row, because the state changes on that cycle.

Test Plan:
1. Release arst_n and hold i_valid=1 with a read to row 3 -> o_ready=0 and o_init_busy=1 for exactly 16 cycles with no o_valid. The first accepted read returns o_data=8'h00 one cycle later.
2. Write row 5, data 8'hFF, mask 4'b0101, then read row 5 with tag 1 -> o_valid=1, o_data=8'h33, o_tag=1, one cycle after the read.
3. Reads of rows 0,1,2 on consecutive cycles after writing 8'h11, 8'h22, 8'h44 -> three consecutive o_valid cycles with o_data 11, 22, 44. Repeat with OUT_REG=1 -> same data, shifted one cycle later.
4. Pulse i_flush in RUN, with a read to row 2 accepted in the prior cycle -> that read returns 8'h44. The request in the flush cycle is dropped, o_ready=0 for 16 cycles, then a read of row 2 returns 8'h00.
5. Instantiate with INIT_BLOCK=2'b10, NUM_ROWS=8 -> init takes 8 cycles, and every row reads 8'hAA.
6. Assert arst_n low in the 7th INIT cycle, then release -> outputs zero immediately and the init runs the full NUM_ROWS cycles again.

Source files
------------

// File: rtl/status_array_ctrl.sv
// rtl/status_array_ctrl.sv - per-set valid/LRU status array with built-in init sequencer
module status_array_ctrl #(
  parameter int unsigned NUM_ROWS = 16,
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned BLOCK_WIDTH = 2,
  parameter int unsigned TAG_WIDTH = 1,
  parameter logic [BLOCK_WIDTH-1:0] INIT_BLOCK = '0,
  parameter int unsigned OUT_REG = 0,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_ROWS),
  localparam int unsigned ROW_WIDTH = NUM_BLOCKS * BLOCK_WIDTH
) (
  input  logic                  gated_clk,
  input  logic                  arst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_BLOCKS-1:0] i_wmask,
  input  logic [ROW_WIDTH-1:0]  i_data,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_ready,
  output logic                  o_init_busy,
  output logic                  o_valid,
  output logic [ROW_WIDTH-1:0]  o_data,
  output logic [TAG_WIDTH-1:0]  o_tag
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [ROW_WIDTH-1:0]  INIT_ROW = {NUM_BLOCKS{INIT_BLOCK}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_we;
  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;

  logic [ROW_WIDTH-1:0]  mem [NUM_ROWS];

  logic                  rd_valid_q;
  logic [ROW_WIDTH-1:0]  rd_data_q;
  logic [TAG_WIDTH-1:0]  rd_tag_q;

  logic                  out_valid;
  logic [ROW_WIDTH-1:0]  out_data;
  logic [TAG_WIDTH-1:0]  out_tag;

  // FSM state and init row counter; reset restarts the full init sweep
  always_ff @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: INIT sweeps every row once, RUN waits for a flush (flush ignored in INIT)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      S_INIT: begin
        init_we = 1'b1;
        if (cnt_q == LAST_ROW) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (i_flush) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_init_busy = (state_q == S_INIT);
  assign o_ready     = (state_q == S_RUN) & ~i_flush;
  assign accept      = i_valid & o_ready;
  assign wr_acc      = accept & i_wen;
  assign rd_acc      = accept & ~i_wen;

  // Storage: init writes whole rows, requests write only the masked blocks
  always_ff @(posedge gated_clk) begin
    if (init_we) begin
      mem[cnt_q] <= INIT_ROW;
    end else if (wr_acc) begin
      for (int b = 0; b < int'(NUM_BLOCKS); b++) begin
        if (i_wmask[b]) begin
          mem[i_addr][b*BLOCK_WIDTH +: BLOCK_WIDTH] <= i_data[b*BLOCK_WIDTH +: BLOCK_WIDTH];
        end
      end
    end
  end

  // First read stage valid flag
  always_ff @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
    end
  end

  // First read stage payload; only loaded on an accepted read
  always_ff @(posedge gated_clk) begin
    if (rd_acc) begin
      rd_data_q <= mem[i_addr];
      rd_tag_q  <= i_tag;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                 out_valid_q;
      logic [ROW_WIDTH-1:0] out_data_q;
      logic [TAG_WIDTH-1:0] out_tag_q;

      // Second stage valid; independent of flush so in-flight results still emerge
      always_ff @(posedge gated_clk or negedge arst_n) begin
        if (!arst_n) begin
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= rd_valid_q;
        end
      end

      // Second stage payload follows the first stage when it holds a result
      always_ff @(posedge gated_clk) begin
        if (rd_valid_q) begin
          out_data_q <= rd_data_q;
          out_tag_q  <= rd_tag_q;
        end
      end

      assign out_valid = out_valid_q;
      assign out_data  = out_data_q;
      assign out_tag   = out_tag_q;
    end else begin : g_no_out_reg
      assign out_valid = rd_valid_q;
      assign out_data  = rd_data_q;
      assign out_tag   = rd_tag_q;
    end
  endgenerate

  // Payload is forced to zero when no result is presented
  assign o_valid = out_valid;
  assign o_data  = out_valid ? out_data : '0;
  assign o_tag   = out_valid ? out_tag : '0;

endmodule

// File: tb/tb_status_array_ctrl.sv
// tb/tb_status_array_ctrl.sv - scoreboard bench for status_array_ctrl (latency 1, latency 2, small array)
module tb_status_array_ctrl;

  typedef struct {
    logic [7:0] d;
    logic       t;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       arst2_n = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       flush = 1'b0;
  logic       valid = 1'b0;
  logic       wen = 1'b0;
  logic [3:0] addr = '0;
  logic [3:0] wmask = '0;
  logic [7:0] data = '0;
  logic       tag = 1'b0;

  logic       valid2 = 1'b0;
  logic [2:0] addr2 = '0;
  logic       tag2 = 1'b0;

  logic       ready0, busy0, ov0, ot0;
  logic [7:0] od0;
  logic       ready1, busy1, ov1, ot1;
  logic [7:0] od1;
  logic       ready2, busy2, ov2, ot2;
  logic [7:0] od2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  status_array_ctrl #(.OUT_REG(0)) dut0 (
    .gated_clk(clk), .arst_n(arst_n), .i_flush(flush), .i_valid(valid), .i_wen(wen),
    .i_addr(addr), .i_wmask(wmask), .i_data(data), .i_tag(tag),
    .o_ready(ready0), .o_init_busy(busy0), .o_valid(ov0), .o_data(od0), .o_tag(ot0)
  );

  status_array_ctrl #(.OUT_REG(1)) dut1 (
    .gated_clk(clk), .arst_n(arst_n), .i_flush(flush), .i_valid(valid), .i_wen(wen),
    .i_addr(addr), .i_wmask(wmask), .i_data(data), .i_tag(tag),
    .o_ready(ready1), .o_init_busy(busy1), .o_valid(ov1), .o_data(od1), .o_tag(ot1)
  );

  status_array_ctrl #(.NUM_ROWS(8), .INIT_BLOCK(2'b10)) dut2 (
    .gated_clk(clk), .arst_n(arst2_n), .i_flush(1'b0), .i_valid(valid2), .i_wen(1'b0),
    .i_addr(addr2), .i_wmask(4'b0000), .i_data(8'h00), .i_tag(tag2),
    .o_ready(ready2), .o_init_busy(busy2), .o_valid(ov2), .o_data(od2), .o_tag(ot2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: pop on every o_valid, otherwise require a zeroed payload
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (ov0) begin
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL dut0 unexpected valid: data=%h tag=%0d cycle=%0d", od0, ot0, cyc);
      end else begin
        e = q0.pop_front();
        if (od0 !== e.d || ot0 !== e.t || cyc != e.c) begin
          n_bad++;
          $display("FAIL dut0 read: got data=%h tag=%0d cycle=%0d expected data=%h tag=%0d cycle=%0d",
                   od0, ot0, cyc, e.d, e.t, e.c);
        end
      end
    end else if (od0 !== 8'h00 || ot0 !== 1'b0) begin
      n_bad++;
      $display("FAIL dut0 idle payload: got data=%h tag=%0d expected 0", od0, ot0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (ov1) begin
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL dut1 unexpected valid: data=%h tag=%0d cycle=%0d", od1, ot1, cyc);
      end else begin
        e = q1.pop_front();
        if (od1 !== e.d || ot1 !== e.t || cyc != e.c) begin
          n_bad++;
          $display("FAIL dut1 read: got data=%h tag=%0d cycle=%0d expected data=%h tag=%0d cycle=%0d",
                   od1, ot1, cyc, e.d, e.t, e.c);
        end
      end
    end else if (od1 !== 8'h00 || ot1 !== 1'b0) begin
      n_bad++;
      $display("FAIL dut1 idle payload: got data=%h tag=%0d expected 0", od1, ot1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (ov2) begin
      if (q2.size() == 0) begin
        n_bad++;
        $display("FAIL dut2 unexpected valid: data=%h tag=%0d cycle=%0d", od2, ot2, cyc);
      end else begin
        e = q2.pop_front();
        if (od2 !== e.d || ot2 !== e.t || cyc != e.c) begin
          n_bad++;
          $display("FAIL dut2 read: got data=%h tag=%0d cycle=%0d expected data=%h tag=%0d cycle=%0d",
                   od2, ot2, cyc, e.d, e.t, e.c);
        end
      end
    end else if (od2 !== 8'h00 || ot2 !== 1'b0) begin
      n_bad++;
      $display("FAIL dut2 idle payload: got data=%h tag=%0d expected 0", od2, ot2);
    end
  end

  // One accepted request to dut0/dut1; called #1 after a rising edge
  task automatic req(input logic w, input logic [3:0] a, input logic [3:0] m,
                     input logic [7:0] d, input logic t, input logic [7:0] exp);
    valid = 1'b1;
    wen   = w;
    addr  = a;
    wmask = m;
    data  = d;
    tag   = t;
    if (!w) begin
      q0.push_back('{exp, t, cyc + 1});
      q1.push_back('{exp, t, cyc + 2});
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    wen   = 1'b0;
  endtask

  // Count cycles until dut0 is ready; optionally pulse flush mid-sequence
  task automatic wait_init(input string nm, input int exp_n, input bit mid_flush);
    int n = 0;
    int busy_bad = 0;
    while (ready0 !== 1'b1 && n < 200) begin
      if (busy0 !== 1'b1) busy_bad++;
      flush = mid_flush && (n == 5);
      @(posedge clk);
      #1;
      n++;
    end
    flush = 1'b0;
    chk({nm, " init cycles"}, n, exp_n);
    chk({nm, " busy during init"}, busy_bad, 0);
    chk({nm, " busy after init"}, {31'd0, busy0}, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy0}, 1);
    chk("reset ready", {31'd0, ready0}, 0);
    chk("reset valid0", {31'd0, ov0}, 0);
    chk("reset data0", {24'd0, od0}, 0);
    chk("reset valid1", {31'd0, ov1}, 0);

    // Release with a read held pending; it must wait out the whole init
    arst_n = 1'b1;
    valid = 1'b1;
    wen = 1'b0;
    addr = 4'd3;
    wait_init("first", 16, 1'b0);
    req(1'b0, 4'd3, 4'h0, 8'h00, 1'b0, 8'h00);
    @(posedge clk); #1;

    // Masked write then read
    req(1'b1, 4'd5, 4'b0101, 8'hFF, 1'b0, 8'h00);
    req(1'b0, 4'd5, 4'h0, 8'h00, 1'b1, 8'h33);

    // Full-row writes then back-to-back reads
    req(1'b1, 4'd0, 4'hF, 8'h11, 1'b0, 8'h00);
    req(1'b1, 4'd1, 4'hF, 8'h22, 1'b0, 8'h00);
    req(1'b1, 4'd2, 4'hF, 8'h44, 1'b0, 8'h00);
    req(1'b0, 4'd0, 4'h0, 8'h00, 1'b1, 8'h11);
    req(1'b0, 4'd1, 4'h0, 8'h00, 1'b0, 8'h22);
    req(1'b0, 4'd2, 4'h0, 8'h00, 1'b1, 8'h44);

    // Zero-mask write is a no-op
    req(1'b1, 4'd1, 4'h0, 8'hEE, 1'b0, 8'h00);
    req(1'b0, 4'd1, 4'h0, 8'h00, 1'b0, 8'h22);

    // Read just before flush, dropped request in flush cycle, flush ignored during init
    req(1'b0, 4'd2, 4'h0, 8'h00, 1'b1, 8'h44);
    flush = 1'b1;
    valid = 1'b1;
    addr = 4'd0;
    #1;
    chk("ready in flush cycle", {31'd0, ready0}, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    valid = 1'b0;
    wait_init("flush", 16, 1'b1);
    req(1'b0, 4'd2, 4'h0, 8'h00, 1'b0, 8'h00);

    // Reset in the 7th init cycle restarts the full sequence
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    chk("midinit reset busy", {31'd0, busy0}, 1);
    chk("midinit reset ready", {31'd0, ready0}, 0);
    chk("midinit reset valid1", {31'd0, ov1}, 0);
    chk("midinit reset data1", {24'd0, od1}, 0);
    @(posedge clk);
    @(posedge clk); #1;
    arst_n = 1'b1;
    wait_init("rearm", 16, 1'b0);
    req(1'b0, 4'd5, 4'h0, 8'h00, 1'b1, 8'h00);
    req(1'b0, 4'd15, 4'h0, 8'h00, 1'b0, 8'h00);

    // Small array with non-zero init pattern
    @(posedge clk); #1;
    arst2_n = 1'b1;
    n = 0;
    while (ready2 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("small init cycles", n, 8);
    for (int r = 0; r < 8; r++) begin
      valid2 = 1'b1;
      addr2 = r[2:0];
      tag2 = r[0];
      q2.push_back('{8'hAA, r[0], cyc + 1});
      @(posedge clk); #1;
    end
    valid2 = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);
    chk("dut2 queue drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
